dbram_arbiter: RTL and testbench

- Shares the single-port data BRAM between two requesters: port 0 is the CPU load/store sub-unit; port 1 is the UART/accelerator DMA path.
- Combinational grant.
- Fixed priority to port 0, with a starvation limiter for port 1.
- Per-port read-return registers with a data_valid/ack handshake.
- Sits between the requesters and the BRAM port; the BRAM has 1-cycle read latency.

---
 rtl/dbram_arbiter_if.sv | 25 ++
 rtl/dbram_arbiter.sv | 109 ++++++++++
 tb/tb_dbram_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dbram_arbiter_if.sv
// Request/return bundle for one requester of the shared data BRAM.
// master = requester side, slave = arbiter side.
interface dbram_arbiter_if #(
  parameter int ADDR_W = 30
);
  logic              valid;
  logic              load;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic              grant;
  logic              data_valid;
  logic [31:0]       rdata;
  logic              ack;

  modport master (
    output valid, load, addr, be, wdata, ack,
    input  grant, data_valid, rdata
  );

  modport slave (
    input  valid, load, addr, be, wdata, ack,
    output grant, data_valid, rdata
  );
endinterface

// File: rtl/dbram_arbiter.sv
// Two-port arbiter in front of a single-port data BRAM (1-cycle read latency).
// Define DBRAM_ARB_RR_EN for round-robin instead of fixed priority + starvation limit.
module dbram_arbiter #(
  parameter int ADDR_W   = 30,
  parameter int MAX_WAIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  dbram_arbiter_if.slave     req0,
  dbram_arbiter_if.slave     req1,
  output logic               bram_en,
  output logic [ADDR_W-1:0]  bram_addr,
  output logic [3:0]         bram_be,
  output logic [31:0]        bram_wdata,
  input  logic [31:0]        bram_rdata
);

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_P0   = 2'b01;
  localparam logic [1:0] OWN_P1   = 2'b10;

  logic [1:0]  owner_q;
  logic        dv0_q, dv1_q;
  logic [31:0] rd0_q, rd1_q;
  logic        elig0, elig1, pick1, grant0, grant1;

  always_comb begin
    elig0 = req0.valid & (~dv0_q | req0.ack);
    elig1 = req1.valid & (~dv1_q | req1.ack);
  end

`ifdef DBRAM_ARB_RR_EN
  // last_q = 1 means port 1 was granted most recently (port 0 wins the next tie)
  logic last_q;

  always_comb pick1 = elig1 & (~elig0 | ~last_q);

  always_ff @(posedge clk) begin
    if (!rst)        last_q <= 1'b1;
    else if (grant0) last_q <= 1'b0;
    else if (grant1) last_q <= 1'b1;
  end
`else
  localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_LIM = WCW'(MAX_WAIT);

  logic [WCW-1:0] wait_q;

  always_comb pick1 = elig1 & (~elig0 | (wait_q == WAIT_LIM));

  always_ff @(posedge clk) begin
    if (!rst)                 wait_q <= '0;
    else if (elig1 & ~grant1) begin
      if (wait_q != WAIT_LIM) wait_q <= wait_q + 1'b1;
    end
    else                      wait_q <= '0;
  end
`endif

  always_comb begin
    grant0 = rst & elig0 & ~pick1;
    grant1 = rst & pick1;
    req0.grant = grant0;
    req1.grant = grant1;
  end

  always_comb begin
    bram_en    = grant0 | grant1;
    bram_addr  = grant1 ? req1.addr  : req0.addr;
    bram_wdata = grant1 ? req1.wdata : req0.wdata;
    bram_be    = 4'b0000;
    if (grant1 && !req1.load)      bram_be = req1.be;
    else if (grant0 && !req0.load) bram_be = req0.be;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q <= OWN_NONE;
      dv0_q   <= 1'b0;
      dv1_q   <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end
    else begin
      if (grant0 && req0.load)      owner_q <= OWN_P0;
      else if (grant1 && req1.load) owner_q <= OWN_P1;
      else                          owner_q <= OWN_NONE;

      if (owner_q == OWN_P0) rd0_q <= bram_rdata;
      if (owner_q == OWN_P1) rd1_q <= bram_rdata;

      if (grant0 && req0.load) dv0_q <= 1'b1;
      else if (req0.ack)       dv0_q <= 1'b0;
      if (grant1 && req1.load) dv1_q <= 1'b1;
      else if (req1.ack)       dv1_q <= 1'b0;
    end
  end

  // data_valid is raised in the cycle the BRAM word appears, so rdata bypasses
  // bram_rdata while the return is landing and the register holds it afterwards.
  // Gating with rst drops a return that lands while reset is asserted.
  always_comb begin
    req0.data_valid = dv0_q & rst;
    req1.data_valid = dv1_q & rst;
    req0.rdata      = (owner_q == OWN_P0) ? bram_rdata : rd0_q;
    req1.rdata      = (owner_q == OWN_P1) ? bram_rdata : rd1_q;
  end

endmodule

// File: tb/tb_dbram_arbiter.sv
// Self-checking bench for dbram_arbiter: directed scenarios plus a randomized
// run against a cycle-level behavioural model of the arbitration rules.
module tb_dbram_arbiter;
  localparam int ADDR_W   = 30;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dbram_arbiter_if #(.ADDR_W(ADDR_W)) r0 ();
  dbram_arbiter_if #(.ADDR_W(ADDR_W)) r1 ();

  logic              bram_en;
  logic [ADDR_W-1:0] bram_addr;
  logic [3:0]        bram_be;
  logic [31:0]       bram_wdata;
  logic [31:0]       bram_rdata;

  logic              v  [2];
  logic              ld [2];
  logic [ADDR_W-1:0] ad [2];
  logic [3:0]        be [2];
  logic [31:0]       wd [2];
  logic              ak [2];

  assign r0.valid = v[0];  assign r0.load = ld[0]; assign r0.addr = ad[0];
  assign r0.be    = be[0]; assign r0.wdata = wd[0]; assign r0.ack = ak[0];
  assign r1.valid = v[1];  assign r1.load = ld[1]; assign r1.addr = ad[1];
  assign r1.be    = be[1]; assign r1.wdata = wd[1]; assign r1.ack = ak[1];

  dbram_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .req0(r0), .req1(r1),
    .bram_en(bram_en), .bram_addr(bram_addr), .bram_be(bram_be),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
  );

  // BRAM model: read-first, 1-cycle latency, byte writes; preload port for setup
  logic [31:0] mem [64];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_addr;
  logic [31:0] pl_data;
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bram_en) begin
      bram_rdata <= mem[bram_addr[5:0]];
      for (int b = 0; b < 4; b++)
        if (bram_be[b]) mem[bram_addr[5:0]][8*b +: 8] <= bram_wdata[8*b +: 8];
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input logic val, input logic load,
                         input logic [ADDR_W-1:0] a, input logic [3:0] b, input logic [31:0] d);
    v[n] = val; ld[n] = load; ad[n] = a; be[n] = b; wd[n] = d;
  endtask

  task automatic idle();
    set_req(0, 1'b0, 1'b1, '0, 4'h0, '0);
    set_req(1, 1'b0, 1'b1, '0, 4'h0, '0);
    ak[0] = 1'b0; ak[1] = 1'b0;
  endtask

  task automatic preload(input logic [5:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    set_req(0, 1'b1, 1'b1, 30'h10, 4'h0, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (r0.grant !== 1'b0) begin failures++; $display("FAIL rst_grant0 cyc%0d got=%b exp=0", i, r0.grant); end
      checks++; if (bram_en !== 1'b0) begin failures++; $display("FAIL rst_bram_en cyc%0d got=%b exp=0", i, bram_en); end
      checks++; if (r0.data_valid !== 1'b0) begin failures++; $display("FAIL rst_dv0 cyc%0d got=%b exp=0", i, r0.data_valid); end
      step();
    end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (r0.grant !== 1'b1) begin failures++; $display("FAIL rel_grant0 got=%b exp=1", r0.grant); end
    checks++; if (r0.rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata0 got=%h exp=0", r0.rdata); end
    step();
    rst = 1'b0;
    idle();
    @(negedge clk);
    checks++; if (r0.data_valid !== 1'b0) begin failures++; $display("FAIL discard_dv0_in_rst got=%b exp=0", r0.data_valid); end
    step();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (r0.data_valid !== 1'b0) begin failures++; $display("FAIL discard_dv0_after got=%b exp=0", r0.data_valid); end
    checks++; if (r0.rdata !== 32'h0) begin failures++; $display("FAIL discard_rdata0 got=%h exp=0", r0.rdata); end
    step();
  endtask

  task automatic test_port0_read();
    do_reset();
    preload(6'h10, 32'hDEADBEEF);
    set_req(0, 1'b1, 1'b1, 30'h10, 4'hF, 32'h0);
    @(negedge clk);
    checks++; if ({r0.grant, r1.grant, bram_en} !== 3'b101) begin failures++; $display("FAIL rd_grant got=%b exp=101", {r0.grant, r1.grant, bram_en}); end
    checks++; if (bram_be !== 4'b0000) begin failures++; $display("FAIL rd_be got=%b exp=0000", bram_be); end
    checks++; if (bram_addr !== 30'h10) begin failures++; $display("FAIL rd_addr got=%h exp=10", bram_addr); end
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (r0.data_valid !== 1'b1 || r0.rdata !== 32'hDEADBEEF) begin
        failures++; $display("FAIL rd_return cyc%0d got=%b/%h exp=1/deadbeef", i, r0.data_valid, r0.rdata); end
      step();
    end
    ak[0] = 1'b1;
    @(negedge clk);
    checks++; if (r0.data_valid !== 1'b1) begin failures++; $display("FAIL rd_dv_in_ack got=%b exp=1", r0.data_valid); end
    step();
    ak[0] = 1'b0;
    @(negedge clk);
    checks++; if (r0.data_valid !== 1'b0 || r0.rdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL rd_after_ack got=%b/%h exp=0/deadbeef", r0.data_valid, r0.rdata); end
    step();
  endtask

  task automatic test_priority_pattern();
    logic exp1;
    do_reset();
    ak[0] = 1'b1; ak[1] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      set_req(0, 1'b1, 1'b1, 30'($urandom_range(0, 63)), 4'h0, '0);
      set_req(1, 1'b1, 1'b1, 30'($urandom_range(0, 63)), 4'h0, '0);
`ifdef DBRAM_ARB_RR_EN
      exp1 = (i % 2) == 1;
`else
      exp1 = (i % (MAX_WAIT + 1)) == MAX_WAIT;
`endif
      @(negedge clk);
      checks++; if (r0.grant !== !exp1 || r1.grant !== exp1) begin
        failures++; $display("FAIL prio_pattern cyc%0d got=%b%b exp=%b%b", i, r0.grant, r1.grant, !exp1, exp1); end
      step();
    end
    idle();
    step();
  endtask

  task automatic test_return_blocking();
    do_reset();
    set_req(0, 1'b1, 1'b1, 30'h3, 4'h0, '0);
    step();
    set_req(0, 1'b1, 1'b1, 30'h4, 4'h0, '0);
    set_req(1, 1'b1, 1'b1, 30'h5, 4'h0, '0);
    ak[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (r0.grant !== 1'b0 || r1.grant !== 1'b1 || r0.data_valid !== 1'b1) begin
        failures++; $display("FAIL block cyc%0d got g0=%b g1=%b dv0=%b exp 0 1 1", i, r0.grant, r1.grant, r0.data_valid); end
      step();
    end
    ak[0] = 1'b1;
    @(negedge clk);
    checks++; if (r0.grant !== 1'b1 || r1.grant !== 1'b0) begin
      failures++; $display("FAIL unblock got g0=%b g1=%b exp 1 0", r0.grant, r1.grant); end
    step();
    idle();
    step();
  endtask

  task automatic test_ack_and_return();
    do_reset();
    preload(6'h30, 32'h12345678);
    preload(6'h31, 32'hCAFEF00D);
    set_req(0, 1'b1, 1'b1, 30'h31, 4'h0, '0);
    step();
    set_req(0, 1'b1, 1'b1, 30'h30, 4'h0, '0);
    ak[0] = 1'b1;
    @(negedge clk);
    checks++; if (r0.grant !== 1'b1 || r0.rdata !== 32'hCAFEF00D) begin
      failures++; $display("FAIL b2b_first got g0=%b rdata=%h exp 1 cafef00d", r0.grant, r0.rdata); end
    step();
    idle();
    @(negedge clk);
    checks++; if (r0.data_valid !== 1'b1 || r0.rdata !== 32'h12345678) begin
      failures++; $display("FAIL ack_and_return got=%b/%h exp=1/12345678", r0.data_valid, r0.rdata); end
    step();
  endtask

  task automatic test_write_then_read();
    do_reset();
    preload(6'h20, 32'h11111111);
    set_req(1, 1'b1, 1'b0, 30'h20, 4'b0011, 32'hAABBCCDD);
    @(negedge clk);
    checks++; if (r1.grant !== 1'b1 || bram_be !== 4'b0011 || bram_wdata !== 32'hAABBCCDD) begin
      failures++; $display("FAIL wr_drive got g1=%b be=%b wd=%h exp 1 0011 aabbccdd", r1.grant, bram_be, bram_wdata); end
    step();
    idle();
    set_req(0, 1'b1, 1'b1, 30'h20, 4'h0, '0);
    @(negedge clk);
    checks++; if (r1.data_valid !== 1'b0 || r0.grant !== 1'b1) begin
      failures++; $display("FAIL wr_no_dv1 got dv1=%b g0=%b exp 0 1", r1.data_valid, r0.grant); end
    step();
    idle();
    @(negedge clk);
    checks++; if (r0.data_valid !== 1'b1 || r0.rdata !== 32'h1111CCDD || r1.data_valid !== 1'b0) begin
      failures++; $display("FAIL wr_then_rd got dv0=%b rd0=%h dv1=%b exp 1 1111ccdd 0", r0.data_valid, r0.rdata, r1.data_valid); end
    step();
  endtask

  task automatic test_random();
    logic [31:0] mm [64];
    logic        xdv [2];
    logic [31:0] xrd [2];
    logic        hold [2];
    logic        e [2];
    logic        w [2];
    int          waited;
    int          last;
    logic [3:0]  xbe;
    do_reset();
    for (int a = 0; a < 64; a++) begin
      mm[a] = $urandom;
      preload(6'(a), mm[a]);
    end
    for (int n = 0; n < 2; n++) begin xdv[n] = 1'b0; xrd[n] = '0; hold[n] = 1'b0; end
    waited = 0;
    last = 1;
    for (int c = 0; c < 2000; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!hold[n])
          set_req(n, ($urandom % 4) != 0, 1'($urandom), 30'($urandom_range(0, 63)), 4'($urandom), $urandom);
        ak[n] = 1'($urandom);
        e[n] = v[n] && (!xdv[n] || ak[n]);
      end
`ifdef DBRAM_ARB_RR_EN
      w[1] = e[1] && (!e[0] || last == 0);
`else
      w[1] = e[1] && (!e[0] || waited == MAX_WAIT);
`endif
      w[0] = e[0] && !w[1];
      xbe = 4'h0;
      if (w[1] && !ld[1]) xbe = be[1];
      if (w[0] && !ld[0]) xbe = be[0];
      @(negedge clk);
      checks++; if (r0.grant !== w[0] || r1.grant !== w[1] || bram_en !== (w[0] || w[1])) begin
        failures++; $display("FAIL rnd_grant cyc%0d got g=%b%b en=%b exp g=%b%b", c, r0.grant, r1.grant, bram_en, w[0], w[1]); end
      checks++; if (bram_addr !== (w[1] ? ad[1] : ad[0]) || bram_be !== xbe ||
                    bram_wdata !== (w[1] ? wd[1] : wd[0])) begin
        failures++; $display("FAIL rnd_bram cyc%0d got a=%h be=%b wd=%h", c, bram_addr, bram_be, bram_wdata); end
      checks++; if (r0.data_valid !== xdv[0] || r1.data_valid !== xdv[1] ||
                    r0.rdata !== xrd[0] || r1.rdata !== xrd[1]) begin
        failures++; $display("FAIL rnd_return cyc%0d got %b/%h %b/%h exp %b/%h %b/%h", c,
          r0.data_valid, r0.rdata, r1.data_valid, r1.rdata, xdv[0], xrd[0], xdv[1], xrd[1]); end
      if (w[0]) last = 0;
      if (w[1]) last = 1;
      waited = (e[1] && !w[1]) ? ((waited < MAX_WAIT) ? waited + 1 : MAX_WAIT) : 0;
      for (int n = 0; n < 2; n++) begin
        if (w[n] && ld[n]) begin xdv[n] = 1'b1; xrd[n] = mm[ad[n][5:0]]; end
        else if (ak[n]) xdv[n] = 1'b0;
        if (w[n] && !ld[n])
          for (int b = 0; b < 4; b++)
            if (be[n][b]) mm[ad[n][5:0]][8*b +: 8] = wd[n][8*b +: 8];
        hold[n] = v[n] && !w[n];
      end
      step();
    end
    idle();
    step();
  endtask

  initial begin
    idle();
    test_reset();
    test_port0_read();
    test_priority_pattern();
    test_return_blocking();
    test_ack_and_return();
    test_write_then_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
